// File: rtl/vga_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R) shared by the requesters and the memory side.
interface vga_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [3:0]        rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/vga_rd_arbiter.sv
// Two-requester AXI4 read arbiter: VGA scanout (s0) has priority, s1 is protected
// from starvation; one burst in flight, owner locked until rlast.
module vga_rd_arbiter #(
  parameter int MAX_S0_RUN = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64
) (
  input  logic             clock,
  input  logic             reset,
  vga_rd_arbiter_if.slave  s0,
  vga_rd_arbiter_if.slave  s1,
  vga_rd_arbiter_if.master m,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_S0_RUN);

  state_t            state;
  logic [3:0]        starve_cnt;
  logic              owner_q;
  logic              arvalid_q;
  logic              busy_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [3:0]        arid_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;

  logic              grant_any;
  logic              grant_sel;
  logic              data_phase;
  logic              route0;
  logic              route1;
  logic              rd_ready;
  logic              beat_last;
  logic [DATA_W-1:0] rdata_fwd;

  // Arbitration: s1 wins only when alone or when s0 has used up its run.
  assign grant_any = (state == IDLE) && !reset && (s0.arvalid || s1.arvalid);
  assign grant_sel = s1.arvalid && (!s0.arvalid || (starve_cnt == RUN_LIMIT));

  assign s0.arready = grant_any && !grant_sel;
  assign s1.arready = grant_any &&  grant_sel;

  // Read-data routing; the reset term cuts the path the moment reset rises mid-burst.
  assign data_phase = (state == DATA) && !reset;
  assign route0     = data_phase && !owner_q;
  assign route1     = data_phase &&  owner_q;
  assign rd_ready   = (route0 && s0.rready) || (route1 && s1.rready);
  assign beat_last  = m.rvalid && rd_ready && m.rlast;
  assign rdata_fwd  = m.rdata;

  assign m.rready   = rd_ready;

  assign s0.rvalid  = route0 && m.rvalid;
  assign s0.rdata   = route0 ? rdata_fwd : '0;
  assign s0.rresp   = route0 ? m.rresp   : 2'b00;
  assign s0.rlast   = route0 && m.rlast;
  assign s0.rid     = route0 ? m.rid     : 4'h0;

  assign s1.rvalid  = route1 && m.rvalid;
  assign s1.rdata   = route1 ? rdata_fwd : '0;
  assign s1.rresp   = route1 ? m.rresp   : 2'b00;
  assign s1.rlast   = route1 && m.rlast;
  assign s1.rid     = route1 ? m.rid     : 4'h0;

  assign m.arvalid  = arvalid_q && !reset;
  assign m.araddr   = araddr_q;
  assign m.arid     = arid_q;
  assign m.arlen    = arlen_q;
  assign m.arsize   = arsize_q;
  assign m.arburst  = arburst_q;

  assign busy       = busy_q && !reset;
  assign owner      = owner_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      starve_cnt <= 4'd0;
      arvalid_q  <= 1'b0;
      busy_q     <= 1'b0;
      araddr_q   <= '0;
      arid_q     <= 4'h0;
      arlen_q    <= 8'h00;
      arsize_q   <= 3'b000;
      arburst_q  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner_q   <= grant_sel;
            araddr_q  <= grant_sel ? s1.araddr  : s0.araddr;
            arid_q    <= grant_sel ? s1.arid    : s0.arid;
            arlen_q   <= grant_sel ? s1.arlen   : s0.arlen;
            arsize_q  <= grant_sel ? s1.arsize  : s0.arsize;
            arburst_q <= grant_sel ? s1.arburst : s0.arburst;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            state     <= ADDR;
            // Count only s0 wins that actually held s1 off.
            if (grant_sel || !s1.arvalid)
              starve_cnt <= 4'd0;
            else if (starve_cnt != RUN_LIMIT)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ADDR: begin
          if (m.arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat_last) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rd_arbiter.sv
// Directed bench for vga_rd_arbiter: cycle table for reset/starvation, hand sequences for bursts.
module tb_vga_rd_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic owner;

  always #5 clk = ~clk;

  vga_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) s0_if ();
  vga_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) s1_if ();
  vga_rd_arbiter_if #(.ADDR_W(32), .DATA_W(64)) m_if ();

  vga_rd_arbiter #(.MAX_S0_RUN(4), .ADDR_W(32), .DATA_W(64)) dut (
    .clock(clk), .reset(rst), .s0(s0_if), .s1(s1_if), .m(m_if), .busy(busy), .owner(owner)
  );

  localparam logic [31:0] S0_ADDR = 32'h1000_0000;
  localparam logic [31:0] S1_ADDR = 32'h8000_0040;
  localparam logic [3:0]  S0_ID   = 4'h2;
  localparam logic [3:0]  S1_ID   = 4'hA;

  typedef struct {
    logic       rst, a0v, a1v, mar, mrv, mrl, rr;
    logic [7:0] exp;  // {s0_arready, s1_arready, m_arvalid, m_rready, s0_rvalid, s1_rvalid, busy, owner}
  } vec_t;

  vec_t tbl[21];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic r, a0, a1, mar, mrv, mrl, rr, input logic [7:0] e);
    vec_t v;
    v.rst = r; v.a0v = a0; v.a1v = a1; v.mar = mar; v.mrv = mrv; v.mrl = mrl; v.rr = rr; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.arvalid = 0; s1_if.arvalid = 0;
    s0_if.rready = 0;  s1_if.rready = 0;
    m_if.arready = 0;  m_if.rvalid = 0; m_if.rlast = 0;
    m_if.rdata = '0;   m_if.rresp = 2'b00; m_if.rid = 4'h0;
  endtask

  // Request from one side, check the zero-wait grant, then pass ADDR with immediate m_arready.
  task automatic start_burst(input bit who, input logic [7:0] len);
    if (who) begin s1_if.arvalid = 1; s1_if.arlen = len; end
    else     begin s0_if.arvalid = 1; s0_if.arlen = len; end
    @(negedge clk);
    chk("grant_arready", {s0_if.arready, s1_if.arready}, who ? 2'b01 : 2'b10);
    next_cyc();
    s0_if.arvalid = 0; s1_if.arvalid = 0; m_if.arready = 1;
    @(negedge clk);
    chk("addr_arvalid", m_if.arvalid, 1'b1);
    chk("addr_fields", {m_if.araddr, m_if.arid, m_if.arlen},
        {who ? S1_ADDR : S0_ADDR, who ? S1_ID : S0_ID, len});
    next_cyc();
    m_if.arready = 0;
  endtask

  // Deliver n beats with rready high; optional error response on beat index err_beat.
  task automatic drain(input bit who, input int n, input int err_beat);
    logic [63:0] d;
    for (int k = 0; k < n; k++) begin
      d = 64'hA5A5_0000_0000_0000 + 64'(k);
      s0_if.rready = 1; s1_if.rready = 1;
      m_if.rvalid = 1; m_if.rdata = d; m_if.rlast = (k == n - 1);
      m_if.rresp = (k == err_beat) ? 2'b10 : 2'b00;
      m_if.rid = who ? S1_ID : S0_ID;
      @(negedge clk);
      chk("beat_rvalid", {s0_if.rvalid, s1_if.rvalid}, who ? 2'b01 : 2'b10);
      chk("beat_rdata", who ? s1_if.rdata : s0_if.rdata, d);
      chk("beat_rresp_rlast_rid",
          who ? {s1_if.rresp, s1_if.rlast, s1_if.rid} : {s0_if.rresp, s0_if.rlast, s0_if.rid},
          {(k == err_beat) ? 2'b10 : 2'b00, k == n - 1, who ? S1_ID : S0_ID});
      chk("beat_other_rdata", who ? s0_if.rdata : s1_if.rdata, 64'h0);
      chk("beat_busy", busy, 1'b1);
      next_cyc();
    end
    m_if.rvalid = 0; m_if.rlast = 0; m_if.rresp = 2'b00;
    @(negedge clk);
    chk("burst_done_idle", busy, 1'b0);
    next_cyc();
  endtask

  initial begin
    int k;
    int cyc;
    bit pat;

    s0_if.araddr = S0_ADDR; s0_if.arid = S0_ID; s0_if.arlen = 8'd0; s0_if.arsize = 3'd3; s0_if.arburst = 2'b01;
    s1_if.araddr = S1_ADDR; s1_if.arid = S1_ID; s1_if.arlen = 8'd3; s1_if.arsize = 3'd3; s1_if.arburst = 2'b01;
    clear_inputs();

    // Reset, then four s0 grants while s1 waits, then s1 gets its turn.
    tbl[0]  = mk(1, 1, 1, 0, 1, 0, 1, 8'b0000_0000);
    tbl[1]  = mk(1, 1, 1, 0, 1, 0, 1, 8'b0000_0000);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0, 0, 8'b1000_0000);
    tbl[3]  = mk(0, 1, 1, 1, 1, 0, 1, 8'b0010_0010);
    tbl[4]  = mk(0, 1, 1, 0, 1, 1, 1, 8'b0001_1010);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 8'b1000_0000);
    tbl[6]  = mk(0, 1, 1, 1, 0, 0, 1, 8'b0010_0010);
    tbl[7]  = mk(0, 1, 1, 0, 1, 1, 1, 8'b0001_1010);
    tbl[8]  = mk(0, 1, 1, 0, 0, 0, 0, 8'b1000_0000);
    tbl[9]  = mk(0, 1, 1, 1, 0, 0, 1, 8'b0010_0010);
    tbl[10] = mk(0, 1, 1, 0, 1, 1, 1, 8'b0001_1010);
    tbl[11] = mk(0, 1, 1, 0, 0, 0, 0, 8'b1000_0000);
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 1, 8'b0010_0010);
    tbl[13] = mk(0, 1, 1, 0, 1, 1, 1, 8'b0001_1010);
    tbl[14] = mk(0, 1, 1, 0, 0, 0, 0, 8'b0100_0000);
    tbl[15] = mk(0, 1, 1, 1, 0, 0, 1, 8'b0010_0011);
    tbl[16] = mk(0, 1, 1, 0, 1, 1, 1, 8'b0001_0111);
    tbl[17] = mk(0, 1, 1, 0, 0, 0, 0, 8'b1000_0001);
    tbl[18] = mk(0, 1, 1, 1, 0, 0, 1, 8'b0010_0010);
    tbl[19] = mk(0, 0, 0, 0, 1, 1, 1, 8'b0001_1010);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);

    rst = 1;
    next_cyc();
    for (int i = 0; i < 21; i++) begin
      rst = tbl[i].rst;
      s0_if.arvalid = tbl[i].a0v; s1_if.arvalid = tbl[i].a1v;
      m_if.arready = tbl[i].mar; m_if.rvalid = tbl[i].mrv; m_if.rlast = tbl[i].mrl;
      s0_if.rready = tbl[i].rr; s1_if.rready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("table_%0d", i),
          {s0_if.arready, s1_if.arready, m_if.arvalid, m_if.rready,
           s0_if.rvalid, s1_if.rvalid, busy, owner}, tbl[i].exp);
      next_cyc();
    end
    clear_inputs();

    // s1 alone, four beats to s1, s0 sees nothing.
    start_burst(1'b1, 8'd3);
    drain(1'b1, 4, -1);

    // m_arready held low for five cycles while s1 waits.
    s0_if.arvalid = 1; s0_if.arlen = 8'd0;
    @(negedge clk);
    chk("stall_grant", {s0_if.arready, s1_if.arready}, 2'b10);
    next_cyc();
    s0_if.arvalid = 0; s1_if.arvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", i),
          {m_if.arvalid, m_if.araddr, m_if.arlen, s0_if.arready, s1_if.arready, m_if.rready},
          {1'b1, S0_ADDR, 8'd0, 1'b0, 1'b0, 1'b0});
      next_cyc();
    end
    m_if.arready = 1; s1_if.arvalid = 0;
    @(negedge clk);
    chk("stall_release", m_if.arvalid, 1'b1);
    next_cyc();
    m_if.arready = 0;
    drain(1'b0, 1, -1);

    // Backpressure from s0 on beats 2 and 3 of an eight-beat burst.
    start_burst(1'b0, 8'd7);
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 30) begin
      pat = !(cyc == 1 || cyc == 3);
      s0_if.rready = pat;
      m_if.rvalid = 1; m_if.rdata = 64'hC000 + 64'(k); m_if.rlast = (k == 7); m_if.rid = S0_ID;
      @(negedge clk);
      chk("bp_rready_mirror", m_if.rready, pat);
      chk("bp_rdata_order", s0_if.rdata, 64'hC000 + 64'(k));
      next_cyc();
      if (pat) k++;
      cyc++;
    end
    m_if.rvalid = 0; m_if.rlast = 0; s0_if.rready = 0;
    chk("bp_beats_delivered", 64'(k), 64'd8);
    chk("bp_cycles_used", 64'(cyc), 64'd10);
    @(negedge clk);
    chk("bp_idle", busy, 1'b0);
    next_cyc();

    // Reset on beat 3 of an eight-beat burst, then a fresh s1 request.
    start_burst(1'b0, 8'd7);
    for (int i = 0; i < 2; i++) begin
      s0_if.rready = 1; m_if.rvalid = 1; m_if.rlast = 0; m_if.rdata = 64'(i);
      next_cyc();
    end
    rst = 1;
    @(negedge clk);
    chk("rst_mid_outputs", {m_if.rready, s0_if.rvalid, busy, m_if.arvalid}, 4'b0000);
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle", {m_if.rready, s0_if.rvalid, busy, owner}, 4'b0000);
    next_cyc();
    m_if.rvalid = 0; s0_if.rready = 0;
    start_burst(1'b1, 8'd3);
    drain(1'b1, 4, -1);

    // Error response on beat 2 of a four-beat burst is forwarded; burst still ends at rlast.
    start_burst(1'b0, 8'd3);
    drain(1'b0, 4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
